// File: rtl/avl_burst_splitter_pkg.sv
// Shared types and constants for the Avalon burst splitter: FSM encoding,
// burst-count width and the largest burst the splitter will honour.
package avl_burst_splitter_pkg;

    localparam int BURST_W   = 5;
    localparam int MAX_BURST = 16;
    localparam int PEND_W    = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_DATA  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4
    } state_t;

    // A zero burst count means one beat; anything above MAX_BURST is clamped.
    function automatic logic [BURST_W-1:0] burst_len(input logic [BURST_W-1:0] cnt);
        if (cnt == '0) return BURST_W'(1);
        if (cnt > BURST_W'(MAX_BURST)) return BURST_W'(MAX_BURST);
        return cnt;
    endfunction

endpackage

// File: rtl/avl_pending_counter.sv
// Tracks single-word reads issued downstream whose data has not yet returned.
// Return data arriving with nothing pending is flagged as underflow and ignored.
module avl_pending_counter
    import avl_burst_splitter_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc,
    input  logic              dec,
    output logic [PEND_W-1:0] count,
    output logic              full,
    output logic              empty,
    output logic              underflow
);

    logic dec_ok;

    assign empty     = (count == '0);
    assign full      = (count >= PEND_W'(MAX));
    assign underflow = dec & empty;
    assign dec_ok    = dec & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !dec_ok) begin
            count <= count + PEND_W'(1);
        end else if (!inc && dec_ok) begin
            count <= count - PEND_W'(1);
        end
    end

endmodule

// File: rtl/avl_burst_splitter.sv
// Converts upstream Avalon-MM bursts into single-word pipelined transfers on a
// non-bursting downstream master, forwarding read data with one cycle latency.
module avl_burst_splitter
    import avl_burst_splitter_pkg::*;
#(
    parameter int pMAX_PENDING = 4,
    parameter int pBYTE_ADDR   = 1
) (
    input  logic               iCLK,
    input  logic               iRESET,
    // Upstream bursting slave. Handshake: a beat transfers on the rising edge
    // where (iWRITE|iREAD) is high and oWAIT_REQUEST is low; oWAIT_REQUEST is
    // a function of state only. Downstream uses the same rule with
    // (oWRITE|oREAD) and iWAIT_REQUEST.
    input  logic [31:0]        iADDRESS,
    input  logic               iWRITE,
    input  logic               iREAD,
    input  logic [31:0]        iWRITE_DATA,
    input  logic [BURST_W-1:0] iBURST_COUNT,
    output logic               oWAIT_REQUEST,
    output logic [31:0]        oREAD_DATA,
    output logic               oREAD_DATA_VALID,
    // Downstream non-bursting pipelined master
    output logic [31:0]        oADDRESS,
    output logic               oWRITE,
    output logic               oREAD,
    output logic [31:0]        oWRITE_DATA,
    input  logic               iWAIT_REQUEST,
    input  logic [31:0]        iREAD_DATA,
    input  logic               iREAD_DATA_VALID,
    output logic               oERROR,
    output state_t             dbg_state
);

    state_t             state, state_nxt;
    logic [31:0]        addr_q, addr_nxt;
    logic [31:0]        wdata_q, wdata_nxt;
    logic [BURST_W-1:0] rem_q, rem_nxt;
    logic               ready_q;
    logic               up_ready, up_wr, up_rd, wr_fire, rd_fire;
    logic [PEND_W-1:0]  pend_count;
    logic               pend_full, pend_empty, pend_underflow;

    // ready_q keeps wait-request high until the first edge after reset release.
    assign up_ready      = ready_q && (state == IDLE || state == WR_DATA);
    assign oWAIT_REQUEST = ~up_ready;
    assign up_wr         = iWRITE & up_ready;
    assign up_rd         = iREAD & ~iWRITE & up_ready;

    assign oWRITE      = (state == WR_ISSUE);
    assign oREAD       = (state == RD_ISSUE) && !pend_full;
    assign wr_fire     = oWRITE & ~iWAIT_REQUEST;
    assign rd_fire     = oREAD & ~iWAIT_REQUEST;
    assign oADDRESS    = (pBYTE_ADDR != 0) ? {addr_q[29:0], 2'b00} : addr_q;
    assign oWRITE_DATA = wdata_q;
    assign dbg_state   = state;

    avl_pending_counter #(.MAX(pMAX_PENDING)) u_pending (
        .clk       (iCLK),
        .rst_n     (iRESET),
        .inc       (rd_fire),
        .dec       (iREAD_DATA_VALID),
        .count     (pend_count),
        .full      (pend_full),
        .empty     (pend_empty),
        .underflow (pend_underflow)
    );

    always_comb begin
        state_nxt = state;
        addr_nxt  = addr_q;
        wdata_nxt = wdata_q;
        rem_nxt   = rem_q;
        case (state)
            IDLE: begin
                if (up_wr) begin
                    addr_nxt  = iADDRESS;
                    wdata_nxt = iWRITE_DATA;
                    rem_nxt   = burst_len(iBURST_COUNT);
                    state_nxt = WR_ISSUE;
                end else if (up_rd) begin
                    addr_nxt  = iADDRESS;
                    rem_nxt   = burst_len(iBURST_COUNT);
                    state_nxt = RD_ISSUE;
                end
            end
            WR_ISSUE: begin
                if (wr_fire) begin
                    addr_nxt  = addr_q + 32'd1;
                    rem_nxt   = rem_q - BURST_W'(1);
                    state_nxt = (rem_q == BURST_W'(1)) ? IDLE : WR_DATA;
                end
            end
            WR_DATA: begin
                // Follow-on beats carry data only; their address/count are ignored.
                if (up_wr) begin
                    wdata_nxt = iWRITE_DATA;
                    state_nxt = WR_ISSUE;
                end
            end
            RD_ISSUE: begin
                if (rd_fire) begin
                    addr_nxt = addr_q + 32'd1;
                    rem_nxt  = rem_q - BURST_W'(1);
                    if (rem_q == BURST_W'(1)) state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (pend_empty || (pend_count == PEND_W'(1) && iREAD_DATA_VALID))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rem_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            wdata_q <= wdata_nxt;
            rem_q   <= rem_nxt;
            ready_q <= 1'b1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            oREAD_DATA       <= '0;
            oREAD_DATA_VALID <= 1'b0;
            oERROR           <= 1'b0;
        end else begin
            oREAD_DATA_VALID <= iREAD_DATA_VALID & ~pend_empty;
            if (iREAD_DATA_VALID && !pend_empty) oREAD_DATA <= iREAD_DATA;
            if (pend_underflow) oERROR <= 1'b1;
        end
    end

endmodule

// File: doc/avl_burst_splitter.md
AVL_BURST_SPLITTER -- requirements
Module: avl_burst_splitter

Interface
REQ-001 SHALL have parameter pMAX_PENDING, default 4: max single-word reads outstanding downstream (1..15).
REQ-002 SHALL have parameter pBYTE_ADDR, default 1: 1 = downstream address is byte address {word_addr[29:0],2'b00}; 0 = word address unchanged.
REQ-003 SHALL have port iCLK, input, 1: sole clock.
REQ-004 SHALL have port iRESET, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have upstream bursting-slave ports (input unless noted): iADDRESS 32 (word address); iWRITE 1; iREAD 1; iWRITE_DATA 32; iBURST_COUNT 5; oWAIT_REQUEST (output) 1; oREAD_DATA (output) 32; oREAD_DATA_VALID (output) 1.
REQ-006 SHALL have downstream non-bursting pipelined-master ports (output unless noted): oADDRESS 32; oWRITE 1; oREAD 1; oWRITE_DATA 32; iWAIT_REQUEST (input) 1; iREAD_DATA (input) 32; iREAD_DATA_VALID (input) 1.
REQ-007 SHALL have port oERROR, output, 1: sticky flag, set on unsolicited read data.

Function
REQ-008 SHALL implement FSM with states IDLE, WR_ISSUE, WR_DATA, RD_ISSUE, RD_WAIT.
REQ-009 oWAIT_REQUEST SHALL be 0 only in IDLE and WR_DATA; upstream beat accepted when (iWRITE|iREAD) & !oWAIT_REQUEST.
REQ-010 IDLE + accepted iWRITE SHALL latch address, data and remaining count = iBURST_COUNT (0 treated as 1), then go to WR_ISSUE.
REQ-011 IDLE + accepted iREAD (with iWRITE=0) SHALL latch address and remaining count, then go to RD_ISSUE; iWRITE wins if both asserted.
REQ-012 WR_ISSUE SHALL hold oWRITE=1 with stable oADDRESS/oWRITE_DATA until iWAIT_REQUEST=0; that cycle decrements remaining and increments address; next state IDLE if remaining becomes 0, else WR_DATA.
REQ-013 WR_DATA SHALL accept next upstream iWRITE beat, latch its data only (iADDRESS/iBURST_COUNT ignored), go to WR_ISSUE.
REQ-014 RD_ISSUE SHALL assert oREAD only while pending < pMAX_PENDING; each cycle with oREAD=1 and iWAIT_REQUEST=0 increments address and pending and decrements remaining; remaining reaching 0 goes to RD_WAIT.
REQ-015 RD_WAIT SHALL return to IDLE in the cycle pending reaches 0; no new command is accepted before then.
REQ-016 Pending counter: +1 on accepted read, -1 on iREAD_DATA_VALID, unchanged when both occur in the same cycle.
REQ-017 iREAD_DATA_VALID with pending=0 SHALL be dropped (not forwarded) and SHALL set oERROR until reset.
REQ-018 oREAD_DATA/oREAD_DATA_VALID SHALL be registered copies of iREAD_DATA/iREAD_DATA_VALID: exactly 1-cycle latency, in order.
REQ-019 Address increment SHALL wrap modulo 2^32 (word domain) without flag.
REQ-020 oWRITE and oREAD SHALL never both be 1.

Reset
REQ-021 iRESET low SHALL asynchronously force: state IDLE; oWRITE, oREAD, oREAD_DATA_VALID, oERROR = 0; oADDRESS, oWRITE_DATA, oREAD_DATA = 0; pending and remaining = 0; oWAIT_REQUEST = 1.
REQ-022 Reset mid-burst SHALL abandon the burst; first command after release starts fresh.
REQ-023 oWAIT_REQUEST SHALL go 0 on the first iCLK edge after reset deassertion.

Structure
REQ-024 State encoding, burst-count width (5) and max burst (16) SHALL live in package avl_burst_splitter_pkg.
REQ-025 Pending tracking SHALL be one sub-module, avl_pending_counter (inc/dec/full/empty/underflow outputs).
REQ-026 Implementation SHALL be single-clock, with no FIFO/RAM.

Verification
REQ-027 Write burst count=3, addr 0x10, data A,B,C, iWAIT_REQUEST=0 -> downstream writes 0x40/A, 0x44/B, 0x48/C, then IDLE.
REQ-028 Read burst count=16, addr 0x0, slave latency 3, pMAX_PENDING=4 -> never more than 4 pending; 16 oREAD_DATA_VALID in order; IDLE after last.
REQ-029 iWAIT_REQUEST held high 5 cycles during WR_ISSUE -> oWRITE/oADDRESS/oWRITE_DATA stable; single write completes.
REQ-030 Addr 0xFFFFFFFF, count=2 read, pBYTE_ADDR=0 -> addresses 0xFFFFFFFF then 0x00000000.
REQ-031 iREAD_DATA_VALID pulse in IDLE -> no oREAD_DATA_VALID; oERROR=1, held until reset.
REQ-032 iRESET low during RD_ISSUE after 2 of 8 reads -> outputs at reset values; new count=1 read completes normally.
